// File: rtl/multiplier_arbiter.sv
// Four-requester round-robin front end for one shared SIZE x SIZE multiplier.
// Each operation runs IDLE -> MUL -> RESP, and the response is held until the granted requester accepts it.

module multiplier #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              over,
  output logic [2*SIZE-1:0] c
);

  // Full-width product; overflow means the upper half is non-zero
  always_comb begin
    c    = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    over = |c[2*SIZE-1:SIZE];
  end

endmodule

module multiplier_arbiter #(
  parameter int SIZE = 4,
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req_valid,
  input  logic [4*SIZE-1:0]   req_a,
  input  logic [4*SIZE-1:0]   req_b,
  output logic [3:0]          req_ready,
  output logic [3:0]          resp_valid,
  input  logic [3:0]          resp_ready,
  output logic [2*SIZE-1:0]   resp_c,
  output logic                resp_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic [1:0]          rr_ptr_r;
  logic [1:0]          grant_r;
  logic [SIZE-1:0]     a_r;
  logic [SIZE-1:0]     b_r;
  logic [2*SIZE-1:0]   resp_c_r;
  logic                resp_over_r;
  logic [3:0]          resp_valid_r;

  logic                found_s;
  logic [1:0]          pick_s;
  logic [2*SIZE-1:0]   mul_c_s;
  logic                mul_over_s;

  multiplier #(.SIZE(SIZE)) u_mul (
    .a    (a_r),
    .b    (b_r),
    .over (mul_over_s),
    .c    (mul_c_s)
  );

  // Round-robin search: first valid requester at or after rr_ptr, wrapping mod 4
  always_comb begin
    logic [1:0] idx;
    found_s = 1'b0;
    pick_s  = rr_ptr_r;
    idx     = rr_ptr_r;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_r + k[1:0];
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        pick_s  = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept strobe only in IDLE; suppressed while reset is asserted since reset wins the edge
  always_comb begin
    req_ready = 4'b0000;
    if ((state_r == IDLE) && found_s && !rst) begin
      req_ready = 4'b0001 << pick_s;
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Arbitration FSM with registered operands, product and response strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 2'd0;
      grant_r      <= 2'd0;
      a_r          <= {SIZE{1'b0}};
      b_r          <= {SIZE{1'b0}};
      resp_c_r     <= {(2*SIZE){1'b0}};
      resp_over_r  <= 1'b0;
      resp_valid_r <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            a_r     <= req_a[pick_s*SIZE +: SIZE];
            b_r     <= req_b[pick_s*SIZE +: SIZE];
            grant_r <= pick_s;
            state_r <= MUL;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          resp_c_r     <= mul_c_s;
          resp_over_r  <= mul_over_s;
          resp_valid_r <= 4'b0001 << grant_r;
          state_r      <= RESP;
        end
        RESP: begin
          // Only the granted requester's resp_ready can release the result
          if (resp_ready[grant_r]) begin
            resp_valid_r <= 4'b0000;
            rr_ptr_r     <= grant_r + 2'd1;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          resp_valid_r <= 4'b0000;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_c     = resp_c_r;
  assign resp_over  = resp_over_r;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter (SIZE=4): a vector table of single transactions,
// followed by fairness, response-stall and reset-abort sequences.

module tb_multiplier_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [7:0]  resp_c;
  logic        resp_over;

  int tests;
  int failed;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  grant;
    logic [7:0]  c;
    logic        over;
  } vec_t;

  vec_t vecs [8];

  multiplier_arbiter #(.SIZE(4), .NREQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_c     (resp_c),
    .resp_over  (resp_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nresp;
    int last_cyc;
    logic [1:0] expg;
    logic [7:0] held_c;

    tests = 0;
    failed = 0;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = 16'h0000;
    req_b = 16'h0000;
    resp_ready = 4'b0000;

    // valid, a {l3,l2,l1,l0}, b, expected grant (rr_ptr evolves through the table), c, over
    vecs[0] = '{4'b0001, 16'h000F, 16'h0009, 2'd0, 8'h87, 1'b1};
    vecs[1] = '{4'b0100, 16'h0F00, 16'h0000, 2'd2, 8'h00, 1'b0};
    vecs[2] = '{4'b0100, 16'h0300, 16'h0400, 2'd2, 8'h0C, 1'b0};
    vecs[3] = '{4'b1111, 16'h5123, 16'h3456, 2'd3, 8'h0F, 1'b0};
    vecs[4] = '{4'b1010, 16'h9040, 16'h2040, 2'd1, 8'h10, 1'b1};
    vecs[5] = '{4'b0011, 16'h00A7, 16'h00B7, 2'd0, 8'h31, 1'b1};
    vecs[6] = '{4'b1000, 16'h1000, 16'hF000, 2'd3, 8'h0F, 1'b0};
    vecs[7] = '{4'b0110, 16'h0300, 16'h0500, 2'd1, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", {12'h000, req_ready}, 16'h0000);
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("rst_resp_valid", {12'h000, resp_valid}, 16'h0000);
    check("rst_resp_c", {8'h00, resp_c}, 16'h0000);
    check("rst_resp_over", {15'h0000, resp_over}, 16'h0000);

    // Vector table; operands are inverted in the MUL cycle to prove they were latched
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_a = vecs[i].a;
      req_b = vecs[i].b;
      resp_ready = 4'b1111;
      #1;
      check($sformatf("v%0d_req_ready", i), {12'h000, req_ready}, {12'h000, 4'b0001 << vecs[i].grant});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_mul_ready", i), {12'h000, req_ready}, 16'h0000);
      req_a = ~req_a;
      req_b = ~req_b;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_resp_valid", i), {12'h000, resp_valid}, {12'h000, 4'b0001 << vecs[i].grant});
      check($sformatf("v%0d_resp_c", i), {8'h00, resp_c}, {8'h00, vecs[i].c});
      check($sformatf("v%0d_resp_over", i), {15'h0000, resp_over}, {15'h0000, vecs[i].over});
      req_valid = 4'b0000;
      @(posedge clk);
    end

    // Fairness: all four valid, lane i computes (i+1)*1
    do_reset();
    req_valid = 4'b1111;
    req_a = 16'h4321;
    req_b = 16'h1111;
    resp_ready = 4'b1111;
    nresp = 0;
    last_cyc = -1;
    expg = 2'd0;
    for (int cyc = 0; cyc < 16 && nresp < 5; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid != 4'b0000) begin
        check("fair_grant", {12'h000, resp_valid}, {12'h000, 4'b0001 << expg});
        check("fair_c", {8'h00, resp_c}, {14'h0000, expg} + 16'd1);
        if (last_cyc >= 0) begin
          check("fair_gap", 16'(cyc - last_cyc), 16'd3);
        end
        last_cyc = cyc;
        expg = expg + 2'd1;
        nresp++;
      end
    end
    check("fair_count", 16'(nresp), 16'd5);
    @(negedge clk);
    req_valid = 4'b0000;

    // Stall: requester 1 holds off, other resp_ready bits must be ignored
    do_reset();
    req_valid = 4'b0010;
    req_a = 16'h00D0;
    req_b = 16'h00B0;
    resp_ready = 4'b0000;
    #1;
    check("stall_accept", {12'h000, req_ready}, 16'h0002);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1111;
    resp_ready = 4'b1101;
    @(posedge clk);
    held_c = 8'h8F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_resp_valid", {12'h000, resp_valid}, 16'h0002);
      check("stall_resp_c", {8'h00, resp_c}, {8'h00, held_c});
      check("stall_req_ready", {12'h000, req_ready}, 16'h0000);
      @(posedge clk);
    end
    @(negedge clk);
    resp_ready = 4'b0010;
    #1;
    check("stall_hs_ready", {12'h000, req_ready}, 16'h0000);
    check("stall_hs_over", {15'h0000, resp_over}, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    check("stall_released", {12'h000, resp_valid}, 16'h0000);
    check("stall_next_grant", {12'h000, req_ready}, 16'h0004);
    req_valid = 4'b0000;
    resp_ready = 4'b0000;

    // Reset while requester 3 is in MUL abandons it
    do_reset();
    req_valid = 4'b1000;
    req_a = 16'hF000;
    req_b = 16'hF000;
    resp_ready = 4'b1111;
    #1;
    check("abort_accept", {12'h000, req_ready}, 16'h0008);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1010;
    req_a = 16'h0050;
    req_b = 16'h0060;
    #1;
    check("abort_rst_ready", {12'h000, req_ready}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_resp_valid", {12'h000, resp_valid}, 16'h0000);
    check("abort_resp_c", {8'h00, resp_c}, 16'h0000);
    check("abort_resp_over", {15'h0000, resp_over}, 16'h0000);
    check("abort_regrant", {12'h000, req_ready}, 16'h0002);
    @(posedge clk);
    @(negedge clk);
    check("abort_no_stale", {12'h000, resp_valid}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("abort_new_valid", {12'h000, resp_valid}, 16'h0002);
    check("abort_new_c", {8'h00, resp_c}, 16'h001E);
    req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 Parameter SIZE, default 4, operand width in bits; product width is 2*SIZE.
REQ-002 Parameter NREQ, fixed at 4, number of requesters; other values are not supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  4  per-requester operation request; bit i belongs to requester i.
REQ-006 req_a  input  4*SIZE  operand A per requester; requester i uses bits [i*SIZE +: SIZE].
REQ-007 req_b  input  4*SIZE  operand B per requester, same packing as req_a.
REQ-008 req_ready  output  4  one-hot accept strobe; requester i's operands are taken when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-009 resp_valid  output  4  one-hot result valid for the granted requester.
REQ-010 resp_ready  input  4  per-requester result acceptance.
REQ-011 resp_c  output  2*SIZE  registered product.
REQ-012 resp_over  output  1  registered overflow flag, high when the product does not fit in SIZE bits.
REQ-013 The block SHALL contain exactly one instance of the shared combinational multiplier (parameter SIZE; ports a, b, over, c) and SHALL not perform multiplication by any other means.

Function
REQ-014 FSM states: IDLE, MUL, RESP; encoding is an implementation choice.
REQ-015 IDLE: if any req_valid bit is high, grant = first valid index at or after rr_ptr, searching upward mod 4; req_ready[grant] SHALL be high combinationally in that cycle; at the edge, latch operands, latch grant, and go to MUL.
REQ-016 IDLE with no valid requests: req_ready = 0 and the state is held.
REQ-017 req_ready SHALL be 0 in MUL and RESP; at most one req_ready bit is ever high.
REQ-018 MUL: the latched operands drive the multiplier; at the edge, capture c into resp_c and over into resp_over, and go to RESP; this state always lasts exactly one cycle.
REQ-019 resp_over SHALL equal the OR of resp_c[2*SIZE-1:SIZE].
REQ-020 RESP: resp_valid[grant] = 1 and all other bits are 0; resp_c and resp_over are held stable while waiting.
REQ-021 RESP exits to IDLE at the edge where resp_ready[grant] = 1; at that edge, rr_ptr becomes (grant+1) mod 4.
REQ-022 resp_ready bits of non-granted requesters SHALL be ignored.
REQ-023 Latency: acceptance edge N, resp_valid high in the cycle after edge N+1 (two cycles); minimum issue interval is 3 cycles.
REQ-024 A new request SHALL NOT be accepted in the same cycle as a response handshake; the next grant is made in IDLE.
REQ-025 Operand inputs are sampled only at the acceptance edge; later changes have no effect on the in-flight result.
REQ-026 Dropping req_valid of a non-granted requester has no effect.
REQ-027 rr_ptr wraps from 3 to 0.
REQ-028 Fairness: with all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-029 While rst = 1 at an edge: state = IDLE, rr_ptr = 0, grant = 0, latched operands = 0, resp_c = 0, resp_over = 0.
REQ-030 During and after reset: req_ready = 0 and resp_valid = 0 until a new request arrives in IDLE.
REQ-031 Reset in MUL or RESP SHALL abandon the in-flight operation with no response issued.
REQ-032 rst takes priority over every other event in the same cycle.

Verification (SIZE=4)
REQ-033 Only req_valid[0], a=4'b1111, b=4'b1001, resp_ready=4'b1111 -> req_ready=4'b0001 at accept; two cycles later resp_valid=4'b0001, resp_c=8'b10000111, resp_over=1.
REQ-034 req_valid[2], a=4'b1111, b=4'b0000 -> resp_c=8'b00000000, resp_over=0, resp_valid=4'b0100; a=4'b0011, b=4'b0100 -> resp_c=8'b00001100, resp_over=0.
REQ-035 req_valid=4'b1111 held, resp_ready=4'b1111 -> grants in order 0,1,2,3,0, each response 3 cycles apart.
REQ-036 Requester 1 granted, resp_ready=0 for 5 cycles -> resp_valid=4'b0010 and resp_c held constant, req_ready=0 throughout; on resp_ready[1]=1 -> IDLE, rr_ptr=2.
REQ-037 rst=1 in MUL cycle for requester 3 -> next cycle resp_valid=0, rr_ptr=0, resp_c=0; a pending req_valid=4'b1010 is then granted to requester 1.
REQ-038 Operands of the granted requester changed one cycle after acceptance -> resp_c reflects the originally accepted values.
